pixel_write_sink: RTL and testbench

//  Receiving end of the pixel-draw stream (x, y, colour, plot) produced by the game sprite drawers.

---
 rtl/pixel_write_sink.sv | 152 +++++++++++++++
 tb/tb_pixel_write_sink.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_sink.sv
// pixel_write_sink: clips and buffers pixel draw requests, issues single-pixel framebuffer writes
// honouring the memory stall, and performs a full-screen fill on request.
module pixel_write_sink #(
  parameter int          X_SCREEN_PIXELS = 160,
  parameter int          Y_SCREEN_PIXELS = 120,
  parameter int          FIFO_DEPTH      = 4,
  parameter logic [2:0]  CLEAR_COLOUR    = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        plot,
  output logic        plot_ready,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic [2:0]  colour,
  input  logic        clear_req,
  output logic        clear_busy,
  output logic        clear_done,
  output logic [14:0] fb_addr,
  output logic [2:0]  fb_data,
  output logic        fb_wren,
  input  logic        fb_busy,
  output logic [7:0]  drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [14:0] LAST_ADDR = 15'(X_SCREEN_PIXELS * Y_SCREEN_PIXELS - 1);
  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
  state_t      state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [14:0] addr_mem_q [FIFO_DEPTH];
  logic [14:0] addr_mem_d [FIFO_DEPTH];
  logic [2:0]  col_mem_q [FIFO_DEPTH];
  logic [2:0]  col_mem_d [FIFO_DEPTH];
  logic [14:0] fb_addr_q, fb_addr_d;
  logic [2:0]  fb_data_q, fb_data_d;
  logic        fb_wren_q, fb_wren_d;
  logic        clear_busy_q, clear_busy_d;
  logic        clear_done_q, clear_done_d;
  logic [7:0]  drop_q, drop_d;
  logic        accept, in_range, push, pop;
  logic [14:0] lin_addr;
  assign plot_ready = count_q < CW'(FIFO_DEPTH);
  assign clear_busy = clear_busy_q;
  assign clear_done = clear_done_q;
  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign fb_wren    = fb_wren_q;
  assign drop_count = drop_q;
  // y*160 + x as shift-add; the address is computed at enqueue time so the FIFO holds ready-to-use addresses
  assign lin_addr = ({8'd0, y} << 7) + ({8'd0, y} << 5) + {7'd0, x};
  always_comb begin
    accept     = plot && plot_ready;
    in_range   = 32'(x) < X_SCREEN_PIXELS && 32'(y) < Y_SCREEN_PIXELS;
    push       = accept && in_range;
    drop_d     = (accept && !in_range && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
    addr_mem_d = addr_mem_q;
    col_mem_d  = col_mem_q;
    if (push) begin
      addr_mem_d[wr_q] = lin_addr;
      col_mem_d[wr_q]  = colour;
    end
    wr_d    = push ? wr_q + AW'(1) : wr_q;
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_comb begin
    state_d      = state_q;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
    fb_wren_d    = fb_wren_q;
    clear_busy_d = clear_busy_q | clear_req;
    clear_done_d = 1'b0;
    pop          = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_busy_q) begin
          state_d   = CLEAR;
          fb_addr_d = '0;
          fb_data_d = CLEAR_COLOUR;
          fb_wren_d = 1'b1;
        end else if (count_q != '0) begin
          pop       = 1'b1;
          state_d   = WRITE;
          fb_addr_d = addr_mem_q[rd_q];
          fb_data_d = col_mem_q[rd_q];
          fb_wren_d = 1'b1;
        end else begin
          fb_wren_d = 1'b0;
        end
      end
      WRITE: begin
        if (!fb_busy) begin
          if (!clear_busy_q && count_q != '0) begin
            pop       = 1'b1;
            fb_addr_d = addr_mem_q[rd_q];
            fb_data_d = col_mem_q[rd_q];
          end else begin
            state_d   = IDLE;
            fb_wren_d = 1'b0;
          end
        end
      end
      CLEAR: begin
        if (!fb_busy) begin
          if (fb_addr_q == LAST_ADDR) begin
            state_d      = IDLE;
            fb_wren_d    = 1'b0;
            clear_busy_d = 1'b0;
            clear_done_d = 1'b1;
          end else begin
            fb_addr_d = fb_addr_q + 15'd1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        fb_wren_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      addr_mem_q   <= '{default: '0};
      col_mem_q    <= '{default: '0};
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      fb_wren_q    <= 1'b0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      addr_mem_q   <= addr_mem_d;
      col_mem_q    <= col_mem_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      fb_wren_q    <= fb_wren_d;
      clear_busy_q <= clear_busy_d;
      clear_done_q <= clear_done_d;
      drop_q       <= drop_d;
    end
  end
endmodule

// File: tb/tb_pixel_write_sink.sv
// tb_pixel_write_sink: directed self-checking bench for pixel_write_sink.
module tb_pixel_write_sink;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        plot = 1'b0;
  logic        plot_ready;
  logic [7:0]  x = '0;
  logic [6:0]  y = '0;
  logic [2:0]  colour = '0;
  logic        clear_req = 1'b0;
  logic        clear_busy, clear_done;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_wren;
  logic        fb_busy = 1'b0;
  logic [7:0]  drop_count;
  int total = 0, passed = 0, fails = 0;
  pixel_write_sink dut (
    .clk(clk), .reset(reset), .plot(plot), .plot_ready(plot_ready), .x(x), .y(y), .colour(colour),
    .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done), .fb_addr(fb_addr),
    .fb_data(fb_data), .fb_wren(fb_wren), .fb_busy(fb_busy), .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic px(input logic p, input int xx, input int yy, input int cc);
    plot   = p;
    x      = 8'(xx);
    y      = 7'(yy);
    colour = 3'(cc);
  endtask
  function automatic logic [31:0] lin(input int xx, input int yy);
    return 32'(yy * 160 + xx);
  endfunction
  int px_x [5] = '{1, 159, 0, 10, 100};
  int px_y [5] = '{2, 119, 0, 50, 1};
  int px_c [5] = '{1, 7, 3, 6, 2};
  initial begin
    int n, bad, k;
    step();
    step();
    chk("rst_wren", fb_wren, 0);
    chk("rst_addr", fb_addr, 0);
    chk("rst_data", fb_data, 0);
    chk("rst_clear_busy", clear_busy, 0);
    chk("rst_clear_done", clear_done, 0);
    chk("rst_drop", drop_count, 0);
    reset = 1'b0;
    step();
    chk("rst_ready", plot_ready, 1);
    // single pixel
    px(1, 73, 105, 5);
    step();
    px(0, 0, 0, 0);
    chk("p1_wren_lat", fb_wren, 0);
    step();
    chk("p1_wren", fb_wren, 1);
    chk("p1_addr", fb_addr, 16873);
    chk("p1_data", fb_data, 5);
    step();
    chk("p1_wren_off", fb_wren, 0);
    // stall: head goes to the write register, four more fill the FIFO
    fb_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      px(1, px_x[i], px_y[i], px_c[i]);
      step();
    end
    chk("stall_ready_low", plot_ready, 0);
    chk("stall_wren", fb_wren, 1);
    chk("stall_addr0", fb_addr, lin(px_x[0], px_y[0]));
    px(1, 20, 20, 1);
    step();
    step();
    chk("stall_hold_addr", fb_addr, lin(px_x[0], px_y[0]));
    chk("stall_hold_data", fb_data, px_c[0]);
    chk("stall_hold_ready", plot_ready, 0);
    px(0, 0, 0, 0);
    fb_busy = 1'b0;
    for (int i = 1; i < 5; i++) begin
      step();
      chk("drain_wren", fb_wren, 1);
      chk("drain_addr", fb_addr, lin(px_x[i], px_y[i]));
      chk("drain_data", fb_data, px_c[i]);
      chk("drain_ready", plot_ready, 1);
    end
    step();
    chk("drain_done", fb_wren, 0);
    // clipping
    px(1, 160, 0, 1);
    step();
    px(1, 0, 120, 2);
    step();
    px(0, 0, 0, 0);
    chk("clip_drop2", drop_count, 2);
    chk("clip_nowren", fb_wren, 0);
    step();
    chk("clip_nowren2", fb_wren, 0);
    px(1, 200, 0, 0);
    for (int i = 0; i < 253; i++) step();
    chk("clip_drop255", drop_count, 255);
    for (int i = 0; i < 3; i++) step();
    px(0, 0, 0, 0);
    chk("clip_sat", drop_count, 255);
    chk("clip_nowren3", fb_wren, 0);
    // full-screen fill with a pixel queued and a repeat request during it
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    chk("clr_busy", clear_busy, 1);
    chk("clr_wren_lat", fb_wren, 0);
    step();
    n = 0;
    bad = 0;
    while (fb_wren && n < 20000) begin
      if (fb_addr !== 15'(n) || fb_data !== 3'd0 || clear_busy !== 1'b1 || clear_done !== 1'b0) bad++;
      if (n == 10) px(1, 5, 5, 4);
      else px(0, 0, 0, 0);
      clear_req = (n == 20);
      n++;
      step();
    end
    px(0, 0, 0, 0);
    clear_req = 1'b0;
    chk("clr_writes", n, 19200);
    chk("clr_bad", bad, 0);
    chk("clr_done", clear_done, 1);
    chk("clr_busy_off", clear_busy, 0);
    step();
    chk("clr_done_pulse", clear_done, 0);
    chk("post_clr_wren", fb_wren, 1);
    chk("post_clr_addr", fb_addr, 805);
    chk("post_clr_data", fb_data, 4);
    step();
    chk("post_clr_idle", fb_wren, 0);
    chk("post_clr_busy", clear_busy, 0);
    // continuous stream
    for (int i = 0; i < 10; i++) begin
      px(1, i * 15, i * 11, i % 8);
      step();
      chk("strm_ready", plot_ready, 1);
      if (i > 0) begin
        chk("strm_wren", fb_wren, 1);
        chk("strm_addr", fb_addr, lin((i - 1) * 15, (i - 1) * 11));
        chk("strm_data", fb_data, (i - 1) % 8);
      end
    end
    px(0, 0, 0, 0);
    step();
    chk("strm_last_addr", fb_addr, lin(135, 99));
    step();
    chk("strm_end", fb_wren, 0);
    // async reset mid-fill with a full FIFO
    clear_req = 1'b1;
    px(1, 1, 1, 1);
    step();
    clear_req = 1'b0;
    px(1, 2, 2, 2);
    step();
    px(1, 3, 3, 3);
    step();
    px(1, 4, 4, 4);
    step();
    px(0, 0, 0, 0);
    k = 0;
    while (!(fb_wren && fb_addr == 15'd500) && k < 2000) begin
      k++;
      step();
    end
    chk("ar_reached500", k < 2000, 1);
    chk("ar_full", plot_ready, 0);
    #2 reset = 1'b1;
    #1;
    chk("ar_wren", fb_wren, 0);
    chk("ar_clear_busy", clear_busy, 0);
    chk("ar_addr", fb_addr, 0);
    chk("ar_ready", plot_ready, 1);
    #1 reset = 1'b0;
    step();
    step();
    step();
    chk("ar_no_pending", fb_wren, 0);
    chk("ar_no_clear", clear_busy, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
